// File: rtl/debug_loader_pkg.sv
// Shared constants for the debug loader: command bytes, FSM states, default address width.
package debug_loader_pkg;

  localparam int unsigned NB_ADDR_DEF = 10;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_DEBUG = 8'h44;
  localparam logic [7:0] ACK_BYTE  = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    LD_CNT,
    LD_BYTE,
    LD_WRITE,
    STEP,
    ACK
  } state_t;

endpackage

// File: rtl/debug_word_assembler.sv
// Big-endian byte-to-word shift register; flags the byte that completes a word.
module debug_word_assembler #(
  parameter int unsigned NB_BITS = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_BITS-1:0] o_word,
  output logic               o_word_ready_c
);

  localparam int unsigned NB_IDX   = 2;
  localparam int unsigned LAST_IDX = NB_BITS / NB_BYTE - 1;

  logic [NB_BITS-1:0] word_q, word_d;
  logic [NB_IDX-1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (i_clr) begin
      word_d = '0;
      idx_d  = '0;
    end else if (i_valid) begin
      // first byte shifts all the way up to the MSBs
      word_d = {word_q[NB_BITS-NB_BYTE-1:0], i_byte};
      idx_d  = (idx_q == NB_IDX'(LAST_IDX)) ? '0 : idx_q + NB_IDX'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign o_word         = word_q;
  assign o_word_ready_c = i_valid && !i_clr && (idx_q == NB_IDX'(LAST_IDX));

endmodule

// File: rtl/debug_loader.sv
// UART-command debug loader driving the Fetch debug port (load, step, run, debug).
// Define DEBUG_ECHO_EN to emit an acknowledge byte on o_tx_* in the ACK state.
module debug_loader
  import debug_loader_pkg::*;
#(
  parameter int unsigned NB_BITS = 32,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF,
  parameter int unsigned NB_BYTE = 8,
  parameter int unsigned NB_CNT  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BITS-1:0] o_data_debug,
  output logic [NB_ADDR-1:0] o_addr_debug,
  output logic               o_wren_debug,
  output logic               o_debug,
  output logic               o_step,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy
);

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               debug_q, debug_d;
  logic               wren_q, wren_d;
  logic               step_q, step_d;
  logic               busy_q;
  logic               asm_clr, asm_valid, word_ready_c;
  logic [NB_BITS-1:0] word;

  debug_word_assembler #(
    .NB_BITS (NB_BITS),
    .NB_BYTE (NB_BYTE)
  ) u_asm (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_clr          (asm_clr),
    .i_valid        (asm_valid),
    .i_byte         (i_rx_data),
    .o_word         (word),
    .o_word_ready_c (word_ready_c)
  );

  // Command decode and load sequencing; bytes are only consumed in IDLE, LD_CNT and LD_BYTE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    debug_d   = debug_q;
    wren_d    = 1'b0;
    step_d    = 1'b0;
    asm_clr   = 1'b0;
    asm_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == NB_BYTE'(CMD_LOAD)) begin
            state_d = LD_CNT;
            debug_d = 1'b1;
            addr_d  = '0;
            asm_clr = 1'b1;
          end else if (i_rx_data == NB_BYTE'(CMD_STEP)) begin
            if (debug_q) begin
              state_d = STEP;
              step_d  = 1'b1;
            end
          end else if (i_rx_data == NB_BYTE'(CMD_RUN)) begin
            state_d = ACK;
            debug_d = 1'b0;
          end else if (i_rx_data == NB_BYTE'(CMD_DEBUG)) begin
            state_d = ACK;
            debug_d = 1'b1;
          end
        end
      end
      LD_CNT: begin
        if (i_rx_valid) begin
          cnt_d   = NB_CNT'(i_rx_data);
          state_d = (i_rx_data == '0) ? ACK : LD_BYTE;
        end
      end
      LD_BYTE: begin
        if (i_rx_valid) begin
          asm_valid = 1'b1;
          if (word_ready_c) begin
            state_d = LD_WRITE;
            wren_d  = 1'b1;
          end
        end
      end
      LD_WRITE: begin
        addr_d  = addr_q + NB_ADDR'(1);
        cnt_d   = cnt_q - NB_CNT'(1);
        state_d = (cnt_q == NB_CNT'(1)) ? ACK : LD_BYTE;
      end
      STEP:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      debug_q <= 1'b1;
      wren_q  <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      debug_q <= debug_d;
      wren_q  <= wren_d;
      step_q  <= step_d;
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef DEBUG_ECHO_EN
  logic [NB_CNT-1:0]  wr_cnt_q, wr_cnt_d;
  logic               load_cmd_q, load_cmd_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;

  // Load acknowledges with the number of words written, other commands with ACK_BYTE.
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    load_cmd_d = load_cmd_q;
    if (state_q == IDLE && i_rx_valid) begin
      load_cmd_d = (i_rx_data == NB_BYTE'(CMD_LOAD));
      if (i_rx_data == NB_BYTE'(CMD_LOAD)) begin
        wr_cnt_d = '0;
      end
    end else if (state_q == LD_WRITE) begin
      wr_cnt_d = wr_cnt_q + NB_CNT'(1);
    end
    tx_valid_d = (state_d == ACK);
    tx_data_d  = load_cmd_d ? NB_BYTE'(wr_cnt_d) : NB_BYTE'(ACK_BYTE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_cnt_q   <= '0;
      load_cmd_q <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      load_cmd_q <= load_cmd_d;
      tx_data_q  <= tx_valid_d ? tx_data_d : '0;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
`else
  assign o_tx_data  = '0;
  assign o_tx_valid = 1'b0;
`endif

  assign o_data_debug = word;
  assign o_addr_debug = addr_q;
  assign o_wren_debug = wren_q;
  assign o_debug      = debug_q;
  assign o_step       = step_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader: load, step/run/debug, mid-load reset, zero load, address wrap.
module tb_debug_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data, rx2_data;
  logic        rx_valid, rx2_valid;

  logic [31:0] data0, data1;
  logic [9:0]  addr0;
  logic [1:0]  addr1;
  logic        wren0, wren1, dbg0, dbg1, step0, step1, txv0, txv1, busy0, busy1;
  logic [7:0]  txd0, txd1;

  int total = 0;
  int bad   = 0;

  int          wa0[$], wa1[$];
  logic [31:0] wd0[$], wd1[$];
  int          dbl_cnt = 0, ovl_cnt = 0, step_cnt = 0, tx_cnt = 0;
  logic        wren0_prev = 1'b0;
  logic [7:0]  tx_last = 8'h00, tx1_last = 8'h00;

  always #5 clk = ~clk;

  debug_loader u0 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_data_debug (data0),
    .o_addr_debug (addr0),
    .o_wren_debug (wren0),
    .o_debug      (dbg0),
    .o_step       (step0),
    .o_tx_data    (txd0),
    .o_tx_valid   (txv0),
    .o_busy       (busy0)
  );

  debug_loader #(.NB_ADDR(2)) u1 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx2_data),
    .i_rx_valid   (rx2_valid),
    .o_data_debug (data1),
    .o_addr_debug (addr1),
    .o_wren_debug (wren1),
    .o_debug      (dbg1),
    .o_step       (step1),
    .o_tx_data    (txd1),
    .o_tx_valid   (txv1),
    .o_busy       (busy1)
  );

  // Log writes, pulses and acknowledges away from the active edge.
  always @(negedge clk) begin
    if (wren0) begin
      wa0.push_back(int'(addr0));
      wd0.push_back(data0);
    end
    if (wren1) begin
      wa1.push_back(int'(addr1));
      wd1.push_back(data1);
    end
    if (wren0 && wren0_prev) dbl_cnt <= dbl_cnt + 1;
    if (wren0 && step0)      ovl_cnt <= ovl_cnt + 1;
    if (step0)               step_cnt <= step_cnt + 1;
    if (txv0) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= txd0;
    end
    if (txv1) tx1_last <= txd1;
    wren0_prev <= wren0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    strobe(b);
    repeat (3) @(negedge clk);
  endtask

  task automatic send2(input logic [7:0] b);
    @(negedge clk);
    rx2_data  = b;
    rx2_valid = 1'b1;
    @(negedge clk);
    rx2_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    rx2_data  = 8'h00;
    rx2_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_debug", dbg0, 1);
    chk("rst_wren", wren0, 0);
    chk("rst_step", step0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_txv", txv0, 0);
    chk("rst_data", data0, 0);
    chk("rst_debug_u1", dbg1, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two-word load
    send(8'h4C);
    chk("ld_busy", busy0, 1);
    chk("ld_debug", dbg0, 1);
    send(8'h02);
    send(8'h12); send(8'h34); send(8'h56);
    strobe(8'h78);
    chk("wr0_lat", wren0, 1);
    chk("wr0_addr", addr0, 0);
    chk("wr0_data", data0, 32'h12345678);
    @(negedge clk);
    chk("wr0_one_cycle", wren0, 0);
    repeat (2) @(negedge clk);
    send(8'h9A); send(8'hBC); send(8'hDE);
    strobe(8'hF0);
    chk("wr1_lat", wren0, 1);
    chk("wr1_addr", addr0, 1);
    chk("wr1_data", data0, 32'h9ABCDEF0);
    repeat (3) @(negedge clk);
    chk("ld_done_busy", busy0, 0);
    chk("ld_nwrites", wa0.size(), 2);
    chk("ld_w0_addr", wa0[0], 0);
    chk("ld_w1_addr", wa0[1], 1);
    chk("ld_w1_data", wd0[1], 32'h9ABCDEF0);
`ifdef DEBUG_ECHO_EN
    chk("ld_echo", tx_last, 8'h02);
`endif

    // Run, ignored step, debug, real step
    send(8'h52);
    chk("run_debug", dbg0, 0);
    strobe(8'h53);
    chk("step_ign_pulse", step0, 0);
    chk("step_ign_busy", busy0, 0);
    repeat (3) @(negedge clk);
    chk("step_ign_cnt", step_cnt, 0);
    send(8'h44);
    chk("dbg_debug", dbg0, 1);
    strobe(8'h53);
    chk("step_lat", step0, 1);
    chk("step_busy", busy0, 1);
    @(negedge clk);
    chk("step_one_cycle", step0, 0);
    repeat (3) @(negedge clk);
    chk("step_cnt", step_cnt, 1);
`ifdef DEBUG_ECHO_EN
    chk("step_echo", tx_last, 8'h06);
`endif

    // Reset in the middle of a load
    send(8'h4C); send(8'h01); send(8'hAA);
    strobe(8'hBB);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_nwrites", wa0.size(), 2);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_debug", dbg0, 1);
    send(8'h4C); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("post_rst_nwrites", wa0.size(), 3);
    chk("post_rst_addr", wa0[2], 0);
    chk("post_rst_data", wd0[2], 32'h11223344);

    // Zero-count load and ignored byte
    send(8'h4C);
    send(8'h00);
    chk("zero_busy", busy0, 0);
    chk("zero_nwrites", wa0.size(), 3);
`ifdef DEBUG_ECHO_EN
    chk("zero_echo", tx_last, 8'h00);
`endif
    strobe(8'h7A);
    chk("ign_busy0", busy0, 0);
    repeat (3) @(negedge clk);
    chk("ign_busy1", busy0, 0);
    chk("ign_nwrites", wa0.size(), 3);

    chk("wren_pulse_len", dbl_cnt, 0);
    chk("wren_step_excl", ovl_cnt, 0);
`ifndef DEBUG_ECHO_EN
    chk("no_echo", tx_cnt, 0);
`endif

    // Address wrap with a 2-bit address
    send2(8'h4C);
    send2(8'h05);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) send2(8'((k + 1) * 16 + j));
    end
    repeat (3) @(negedge clk);
    chk("wrap_nwrites", wa1.size(), 5);
    for (int k = 0; k < 5; k++) begin
      logic [31:0] exp_w;
      exp_w = {8'((k + 1) * 16), 8'((k + 1) * 16 + 1), 8'((k + 1) * 16 + 2), 8'((k + 1) * 16 + 3)};
      if (k < wa1.size()) begin
        chk($sformatf("wrap_addr%0d", k), wa1[k], k % 4);
        chk($sformatf("wrap_data%0d", k), wd1[k], exp_w);
      end
    end
    chk("wrap_busy", busy1, 0);
`ifdef DEBUG_ECHO_EN
    chk("wrap_echo", tx1_last, 8'h05);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_loader.md
Name: debug_loader

Overview:
- Initiator end of the Fetch stage debug port (instruction write data, write enable, debug mode, step).
- Consumes a byte stream from the board UART receiver and decodes single-byte commands.
- Loads program words into instruction memory, holds the pipeline in debug mode, single-steps it, or releases it to run.
- Sits beside the Mips top; drives the Fetch debug inputs that are currently tied off.

Parameters:
- NB_BITS, 32, instruction/data word width (must be a multiple of 8)
- NB_ADDR, 10, instruction memory word-address width
- NB_BYTE, 8, UART byte width
- NB_CNT, 8, word-count field width of the load command

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- o_data_debug  out  NB_BITS  instruction word to write
- o_addr_debug  out  NB_ADDR  instruction memory word address
- o_wren_debug  out  1  one-cycle instruction memory write strobe
- o_debug  out  1  pipeline held in debug mode (PC frozen unless stepped)
- o_step  out  1  one-cycle single-step pulse
- o_tx_data  out  NB_BYTE  acknowledge byte (DEBUG_ECHO_EN only)
- o_tx_valid  out  1  acknowledge strobe (DEBUG_ECHO_EN only)
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0 except o_debug=1. The processor stays halted until it receives 'R'.
- Reset is synchronous and active-high, and wins over every other event. Reset in the middle of a load discards the partial word and the address counter. Words already written stay in memory.
- Commands (byte received in IDLE):
  - 0x4C 'L': load
  - 0x53 'S': step
  - 0x52 'R': run, o_debug<=0
  - 0x44 'D': debug, o_debug<=1
  - Any other byte is ignored and the FSM stays in IDLE.
- FSM states: IDLE, LD_CNT, LD_BYTE, LD_WRITE, STEP, ACK.
  - IDLE --'L'--> LD_CNT. o_debug<=1 is forced so the pipeline cannot fetch while memory is written. Address counter <=0.
  - LD_CNT --rx--> count register <= byte. A count of 0 goes to ACK with no writes; otherwise goes to LD_BYTE.
  - LD_BYTE: each rx byte shifts into the word register, big-endian (first byte -> bits [NB_BITS-1:NB_BITS-8]). A 2-bit byte index counts 0..3. On the 4th byte go to LD_WRITE.
  - LD_WRITE, exactly one cycle: o_wren_debug=1, o_data_debug=word, o_addr_debug=address counter. Then address+1 and count-1. If count becomes 0 go to ACK, else go to LD_BYTE.
  - STEP, entered on 'S' only when o_debug=1: o_step=1 for exactly one cycle, then ACK. 'S' with o_debug=0 is ignored (no pulse, no ACK).
  - 'R' and 'D' update o_debug in the cycle after the byte and go to ACK.
  - ACK: one cycle, then IDLE.
- Addressing: the address counter wraps modulo 2^NB_ADDR with no error. A count up to 255 words is legal per load.
- Timing rules:
  - i_rx_valid is ignored in LD_WRITE, STEP and ACK. The UART byte period is far longer than these one-cycle states, so no byte is lost.
  - i_rx_valid low means hold state.
  - o_wren_debug and o_step never assert in the same cycle.
- Latency: 4th byte strobe -> o_wren_debug on the next cycle. 'S' strobe -> o_step on the next cycle.

Optional Feature:
- DEBUG_ECHO_EN defined: in ACK, o_tx_valid=1 for one cycle.
  - o_tx_data=0x06 for completed commands.
  - For 'L', o_tx_data is the low byte of the number of words written.
- DEBUG_ECHO_EN undefined: o_tx_data=0, o_tx_valid=0, and no echo logic is built. ACK remains a one-cycle pass-through.

Decomposition:
- The shared include holds:
  - command byte constants CMD_LOAD, CMD_STEP, CMD_RUN, CMD_DEBUG, ACK_BYTE
  - FSM state encodings
  - NB_ADDR default
- One sub-module is natural: debug_word_assembler (byte shift register plus 2-bit index, emits word_ready). The FSM stays in debug_loader.

Test Plan:
- Reset -> o_debug=1, o_wren_debug=0, o_step=0, o_addr_debug=0, o_busy=0.
- Send 0x4C,0x02,12 34 56 78,9A BC DE F0 -> writes 0x12345678@0 then 0x9ABCDEF0@1, each o_wren_debug one cycle. With DEBUG_ECHO_EN: tx 0x02.
- Send 0x52 -> o_debug=0. Then 0x53 -> no o_step. Then 0x44 -> o_debug=1. Then 0x53 -> single-cycle o_step one cycle after the strobe.
- Send 0x4C,0x01,0xAA,0xBB then assert i_rst -> no write occurs. After reset, 0x4C,0x01,11 22 33 44 -> 0x11223344@0.
- Send 0x4C,0x00 -> no write, back to IDLE. Send 0x7A -> ignored, o_busy stays 0.
- With NB_ADDR=2, load 5 words -> addresses 0,1,2,3,0 (wrap). The 5th word overwrites address 0.
